// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
// The result is computed when the op launches and is committed after a fixed busy window.

module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic        [31:0] cnt;
  logic        [31:0] hi_tmp;
  logic        [31:0] lo_tmp;
  logic               wr_tmp;

  logic               launch;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] hi_next;
  logic        [31:0] lo_next;
  logic               wr_next;

  assign launch = (state == IDLE) && Start && (MDUOp >= 4'd1) && (MDUOp <= 4'd4);

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  always_comb begin
    hi_next = HI;
    lo_next = LO;
    wr_next = 1'b1;
    case (MDUOp)
      4'd1: {hi_next, lo_next} = prod_s;
      4'd2: {hi_next, lo_next} = prod_u;
      4'd3: begin
        if (B == 32'd0) begin
          wr_next = 1'b0;
        end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
          // Quotient overflows; pin the architecturally defined result.
          lo_next = 32'h8000_0000;
          hi_next = 32'd0;
        end else begin
          lo_next = $signed(A) / $signed(B);
          hi_next = $signed(A) % $signed(B);
        end
      end
      4'd4: begin
        if (B == 32'd0) begin
          wr_next = 1'b0;
        end else begin
          lo_next = A / B;
          hi_next = A % B;
        end
      end
      default: wr_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      Busy   <= 1'b0;
      cnt    <= 32'd0;
      HI     <= 32'd0;
      LO     <= 32'd0;
      hi_tmp <= 32'd0;
      lo_tmp <= 32'd0;
      wr_tmp <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state  <= RUN;
            Busy   <= 1'b1;
            cnt    <= (MDUOp <= 4'd2) ? 32'(MULT_CYCLES) : 32'(DIV_CYCLES);
            hi_tmp <= hi_next;
            lo_tmp <= lo_next;
            wr_tmp <= wr_next;
          end else if (MDUOp == 4'd5) begin
            HI <= A;
          end else if (MDUOp == 4'd6) begin
            LO <= A;
          end
        end
        RUN: begin
          if (cnt == 32'd1) begin
            state <= IDLE;
            Busy  <= 1'b0;
            cnt   <= 32'd0;
            if (wr_tmp) begin
              HI <= hi_tmp;
              LO <= lo_tmp;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign MDUOut = (MDUOp == 4'd7) ? HI : (MDUOp == 4'd8) ? LO : 32'd0;

endmodule
